// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Owner encoding and the burst counter width live here so the bench and RTL agree.
package ram_arbiter_pkg;

  localparam int BURST_W = 4;
  localparam logic [BURST_W-1:0] BURST_SAT = '1;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    P0   = 2'd1,
    P1   = 2'd2
  } owner_t;

  // The port that is not p; NONE maps to P0 so callers never see an illegal owner.
  function automatic owner_t other_port(input owner_t p);
    return (p == P0) ? P1 : P0;
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port synchronous RAM.
// A port keeps the RAM for up to MAX_BURST back-to-back grants while the other port waits.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_we,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  owner_t               owner_q, owner_d;
  owner_t               last_owner_q, last_owner_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic                 rvalid0_q, rvalid0_d;
  logic                 rvalid1_q, rvalid1_d;

  owner_t               winner;
  logic                 own_req;
  logic                 oth_req;
  logic                 burst_open;

  // Winner select, RAM mux and next state; reset forces the idle outputs.
  always_comb begin
    winner       = NONE;
    own_req      = 1'b0;
    oth_req      = 1'b0;
    burst_open   = (int'(burst_cnt_q) < MAX_BURST);
    gnt0         = 1'b0;
    gnt1         = 1'b0;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    rvalid0_d    = 1'b0;
    rvalid1_d    = 1'b0;

    if (owner_q == P0) begin
      own_req = req0;
      oth_req = req1;
    end else if (owner_q == P1) begin
      own_req = req1;
      oth_req = req0;
    end

    if (!reset) begin
      if (owner_q == NONE) begin
        if (req0 && req1) begin
          winner = other_port(last_owner_q);
        end else if (req0) begin
          winner = P0;
        end else if (req1) begin
          winner = P1;
        end
      end else if (own_req && (burst_open || !oth_req)) begin
        winner = owner_q;
      end else if (oth_req) begin
        winner = other_port(owner_q);
      end
    end

    if (winner == P0) begin
      gnt0      = 1'b1;
      ram_we    = we0;
      ram_re    = ~we0;
      ram_addr  = addr0;
      ram_wdata = wdata0;
      rvalid0_d = ~we0;
    end else if (winner == P1) begin
      gnt1      = 1'b1;
      ram_we    = we1;
      ram_re    = ~we1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
      rvalid1_d = ~we1;
    end

    if (reset) begin
      owner_d      = NONE;
      last_owner_d = P1;
      burst_cnt_d  = '0;
    end else if (winner != NONE) begin
      owner_d      = winner;
      last_owner_d = winner;
      if (winner == owner_q) begin
        burst_cnt_d = (burst_cnt_q == BURST_SAT) ? burst_cnt_q
                                                 : burst_cnt_q + BURST_W'(1);
      end else begin
        burst_cnt_d = BURST_W'(1);
      end
    end else begin
      owner_d     = NONE;
      burst_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    owner_q      <= owner_d;
    last_owner_q <= last_owner_d;
    burst_cnt_q  <= burst_cnt_d;
    rvalid0_q    <= rvalid0_d;
    rvalid1_q    <= rvalid1_d;
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  // RAM read data is already registered inside the RAM, so it passes straight through.
  assign rdata   = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus random traffic
// compared against a grant-history reference model and a shadow copy of the RAM.
module tb_ram_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;
  logic          ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ramRdata;

  logic          altGnt0, altGnt1, altRv0, altRv1, altWe, altRe;
  logic [DW-1:0] altRdata, altWdata;
  logic [AW-1:0] altAddr;

  logic [DW-1:0] ramMem [256];
  logic [DW-1:0] refMem [256];

  int checkCount = 0;
  int errorCount = 0;

  // reference model: grant history rather than arbiter state
  int   prevGrant;
  int   streak;
  int   lastGrant;
  int   lastWinner;
  logic expRv0, expRv1;
  logic [DW-1:0] expRdata;
  int   waitCnt [2];

  logic obsGnt0, obsGnt1, obsRv0, obsRv1, obsAltGnt0;
  logic [DW-1:0] obsRdata;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_we(ram_we), .ram_re(ram_re),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ramRdata)
  );

  // second arbiter with single-grant bursts, sharing the same stimulus
  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(1)) u_alt (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(altGnt0), .gnt1(altGnt1), .rvalid0(altRv0), .rvalid1(altRv1),
    .rdata(altRdata), .ram_we(altWe), .ram_re(altRe),
    .ram_addr(altAddr), .ram_wdata(altWdata), .ram_rdata(ramRdata)
  );

  // behavioural synchronous-read RAM driven by the main arbiter
  always @(posedge clk) begin
    if (ram_we) ramMem[ram_addr] <= ram_wdata;
    if (ram_re) ramRdata <= ramMem[ram_addr];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // previous grantee keeps the RAM while under its burst limit or unopposed;
  // after an idle cycle a tie goes to whoever was not granted last
  function automatic int pickWinner();
    logic r [2];
    r[0] = req0;
    r[1] = req1;
    if (reset) return -1;
    if (prevGrant >= 0) begin
      if (r[prevGrant] && (streak < MB || !r[1-prevGrant])) return prevGrant;
      if (r[1-prevGrant]) return 1 - prevGrant;
      return -1;
    end
    if (r[0] && r[1]) return 1 - lastGrant;
    if (r[0]) return 0;
    if (r[1]) return 1;
    return -1;
  endfunction

  task automatic runChecks();
    int w;
    logic selWe;
    logic [AW-1:0] selAddr;
    logic [DW-1:0] selData;
    logic reqs [2];
    w = pickWinner();
    selWe   = (w == 0) ? we0 : (w == 1) ? we1 : 1'b0;
    selAddr = (w == 0) ? addr0 : (w == 1) ? addr1 : '0;
    selData = (w == 0) ? wdata0 : (w == 1) ? wdata1 : '0;

    checkOutput("gnt0", 32'(gnt0), 32'(w == 0));
    checkOutput("gnt1", 32'(gnt1), 32'(w == 1));
    checkOutput("ram_we", 32'(ram_we), 32'(w >= 0 && selWe));
    checkOutput("ram_re", 32'(ram_re), 32'(w >= 0 && !selWe));
    checkOutput("ram_addr", 32'(ram_addr), 32'(selAddr));
    checkOutput("ram_wdata", 32'(ram_wdata), 32'(selData));
    checkOutput("rvalid0", 32'(rvalid0), 32'(expRv0));
    checkOutput("rvalid1", 32'(rvalid1), 32'(expRv1));
    if (expRv0 || expRv1) checkOutput("rdata", 32'(rdata), 32'(expRdata));
    checkOutput("gntExclusive", 32'(gnt0 & gnt1), 32'd0);
    checkOutput("strobeExclusive", 32'(ram_we & ram_re), 32'd0);
    checkOutput("altExclusive", 32'(altGnt0 & altGnt1), 32'd0);

    reqs[0] = req0;
    reqs[1] = req1;
    for (int p = 0; p < 2; p++) begin
      if (reset || !reqs[p]) begin
        waitCnt[p] = 0;
      end else if (w == p) begin
        checkOutput($sformatf("waitBound%0d", p), 32'(waitCnt[p] <= MB), 32'd1);
        waitCnt[p] = 0;
      end else begin
        waitCnt[p]++;
      end
    end

    obsGnt0    = gnt0;
    obsGnt1    = gnt1;
    obsRv0     = rvalid0;
    obsRv1     = rvalid1;
    obsRdata   = rdata;
    obsAltGnt0 = altGnt0;

    if (reset) begin
      prevGrant = -1;
      lastGrant = 1;
      streak    = 0;
      expRv0    = 1'b0;
      expRv1    = 1'b0;
    end else begin
      if (w >= 0) begin
        streak    = (w == prevGrant) ? ((streak < 15) ? streak + 1 : 15) : 1;
        prevGrant = w;
        lastGrant = w;
        if (selWe) refMem[selAddr] = selData;
        else       expRdata = refMem[selAddr];
      end else begin
        prevGrant = -1;
        streak    = 0;
      end
      expRv0 = (w == 0) && !selWe;
      expRv1 = (w == 1) && !selWe;
    end
    lastWinner = w;
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic r0, input logic w0, input logic [AW-1:0] a0,
                               input logic [DW-1:0] d0,
                               input logic r1, input logic w1, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d1);
    reset  = rst;
    req0   = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1   = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    @(negedge clk);
    runChecks();
    @(posedge clk);
    #1;
  endtask

  // random requester that holds its request until granted, sometimes withdrawing
  task automatic randomCycle();
    if (lastWinner == 0 || !req0) begin
      req0   = ($urandom_range(0, 2) != 0);
      we0    = 1'($urandom_range(0, 1));
      addr0  = AW'($urandom_range(0, 15));
      wdata0 = DW'($urandom);
    end else if ($urandom_range(0, 15) == 0) begin
      req0 = 1'b0;
    end
    if (lastWinner == 1 || !req1) begin
      req1   = ($urandom_range(0, 2) != 0);
      we1    = 1'($urandom_range(0, 1));
      addr1  = AW'($urandom_range(0, 15));
      wdata1 = DW'($urandom);
    end else if ($urandom_range(0, 15) == 0) begin
      req1 = 1'b0;
    end
    reset = ($urandom_range(0, 63) == 0);
    @(negedge clk);
    runChecks();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] mainPattern;
    logic [8:0] altPattern;
    for (int i = 0; i < 256; i++) begin
      ramMem[i] = DW'(i) ^ 8'h4A;
      refMem[i] = DW'(i) ^ 8'h4A;
    end
    ramRdata   = '0;
    prevGrant  = -1;
    lastGrant  = 1;
    streak     = 0;
    lastWinner = -1;
    expRv0     = 1'b0;
    expRv1     = 1'b0;
    expRdata   = '0;
    waitCnt[0] = 0;
    waitCnt[1] = 0;

    $display("[TB] reset, then both ports held in a tie");
    applyStimulus(1, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    mainPattern = '0;
    altPattern  = '0;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1, 0, 8'h01, 8'h00, 1, 0, 8'h02, 8'h00);
      mainPattern = {mainPattern[7:0], obsGnt0};
      altPattern  = {altPattern[7:0], obsAltGnt0};
    end
    checkOutput("tieBurstPattern", 32'(mainPattern), 32'(9'b111100001));
    checkOutput("tieAlternate", 32'(altPattern), 32'(9'b101010101));

    $display("[TB] single port 0 read");
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("p0ReadGnt", 32'(obsGnt0), 32'd1);
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("p0ReadValid", 32'(obsRv0), 32'd1);
    checkOutput("p0ReadData", 32'(obsRdata), 32'h5A);

    $display("[TB] port 1 write then port 0 read-back");
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hA5);
    applyStimulus(0, 1, 0, 8'h20, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    checkOutput("readBackValid", 32'(obsRv0), 32'd1);
    checkOutput("readBackData", 32'(obsRdata), 32'hA5);
    checkOutput("readBackNoRv1", 32'(obsRv1), 32'd0);

    $display("[TB] idle gap then tie");
    applyStimulus(0, 1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 1, 0, 8'h03, 8'h00, 1, 0, 8'h04, 8'h00);
    checkOutput("gapTieGnt1", 32'(obsGnt1), 32'd1);

    $display("[TB] reset right after a port 1 read grant");
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h05, 8'h00);
    applyStimulus(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    applyStimulus(0, 1, 0, 8'h06, 8'h00, 1, 0, 8'h07, 8'h00);
    checkOutput("resetDropsRv1", 32'(obsRv1), 32'd0);
    checkOutput("resetTieGnt0", 32'(obsGnt0), 32'd1);

    $display("[TB] random traffic");
    applyStimulus(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 600; i++) randomCycle();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width.
REQ-003 SHALL have parameter MAX_BURST, default 4, max consecutive grants to one owner while the other requests; legal 1..15.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 req0 / req1  input  1  access request; port 0 = CPU core, port 1 = UART debug/DMA.
REQ-007 we0 / we1  input  1  1 = write, 0 = read; qualifies reqN.
REQ-008 addr0 / addr1  input  ADDR_W  access address.
REQ-009 wdata0 / wdata1  input  DATA_W  write data.
REQ-010 gnt0 / gnt1  output  1  access issued to RAM this cycle (combinational from state and req).
REQ-011 rvalid0 / rvalid1  output  1  read data valid, one cycle after a granted read.
REQ-012 rdata  output  DATA_W  read data, shared by both ports; qualify with rvalidN.
REQ-013 ram_we / ram_re  output  1  RAM write/read strobe.
REQ-014 ram_addr  output  ADDR_W  RAM address.
REQ-015 ram_wdata  output  DATA_W  RAM write data.
REQ-016 ram_rdata  input  DATA_W  RAM read data, valid the cycle after ram_re (synchronous read).

Function
REQ-017 SHALL hold state: owner in {NONE, P0, P1}, last_owner in {P0, P1}, burst_cnt (4 bits).
REQ-018 SHALL select the winner each cycle by these rules, in order:
  - owner requests and (burst_cnt < MAX_BURST or other idle) -> owner wins;
  - else other requests -> other wins;
  - else none.
REQ-019 In state NONE with both requesting, SHALL grant the port != last_owner; with one requesting, SHALL grant that port.
REQ-020 Winner SHALL get gntN=1 and drive ram_addr/ram_wdata from its inputs, ram_we=weN, ram_re=~weN, all in the same cycle; the loser's gnt SHALL be 0.
REQ-021 With no winner: ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0.
REQ-022 On a grant, SHALL load owner=winner and last_owner=winner; burst_cnt SHALL increment (saturating at 15) if winner==owner, else load 1.
REQ-023 With no winner, SHALL set owner=NONE and burst_cnt=0; last_owner is unchanged.
REQ-024 SHALL never assert gnt0 and gnt1 in the same cycle.
REQ-025 A requester SHALL hold req/we/addr/wdata stable until gnt; deasserting req before gnt withdraws the request with no RAM access.
REQ-026 rvalidN SHALL be a register of (gntN & ~weN); rdata SHALL pass ram_rdata through combinationally.
REQ-027 When MAX_BURST=1 and both ports hold req, grants SHALL strictly alternate every cycle.
REQ-028 Wait bound: a held request SHALL be granted within MAX_BURST cycles.

Reset
REQ-029 While reset=1, SHALL hold gnt0=gnt1=0, ram_we=ram_re=0, ram_addr=0, ram_wdata=0 regardless of req.
REQ-030 Reset SHALL set owner=NONE, last_owner=P1 (so P0 wins the first tie), burst_cnt=0, rvalid0=rvalid1=0.
REQ-031 Reset asserted in the cycle after a granted read SHALL clear rvalid; the read result is dropped.

Structure
REQ-032 Shared package ram_arbiter_pkg SHALL hold the owner enum (NONE, P0, P1) and the burst counter width constant.
REQ-033 SHALL be a single module with no sub-modules; the winner select is one combinational block feeding one registered state block.

Verification
REQ-034 Single P0 read: req0=1, we0=0, addr0=0x10, RAM[0x10]=0x5A -> gnt0 same cycle, ram_re=1, ram_addr=0x10; next cycle rvalid0=1, rdata=0x5A.
REQ-035 Tie after reset: req0=req1=1, both held -> gnt0 for 4 cycles, then gnt1 for 4 cycles, then gnt0 again (MAX_BURST=4).
REQ-036 Write then read-back: P1 writes 0xA5 to 0x20, then P0 reads 0x20 -> P0 rvalid0=1 with rdata=0xA5, and rvalid1 never asserted.
REQ-037 Idle gap: P0 granted, then req0=0 for 1 cycle, then req0=req1=1 -> owner=NONE during the gap, P1 wins (last_owner=P0).
REQ-038 Reset mid-burst: reset asserted in the cycle after a P1 read grant -> rvalid1=0 next cycle; then req0=req1=1 -> gnt0 first.
REQ-039 Every test: assert gnt0&gnt1 never true, and ram_we&ram_re never true.
